// File: rtl/systolic_drain_pkg.sv
// Shared defaults, result-width derivation and FSM encoding for the systolic drain block.
package systolic_pkg;

    localparam int DEF_ARRAY_SIZE = 8;
    localparam int DEF_DATA_WIDTH = 4;

    function automatic int acc_width(input int dw);
        return dw * dw;
    endfunction

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/systolic_drain_if.sv
// Downstream valid/ready row stream leaving the systolic drain.
interface systolic_drain_if import systolic_pkg::*; #(
    parameter int WIDTH = DEF_ARRAY_SIZE * acc_width(DEF_DATA_WIDTH)
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/systolic_drain_fifo.sv
// First-word-fall-through row FIFO; a push into a full FIFO survives only if a pop frees a slot.
module systolic_drain_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             empty, full, do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = !empty && pop;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/systolic_drain.sv
// Deskews the diagonal result wavefront of a systolic array into whole rows and queues them.
// Optional SYSTOLIC_DRAIN_ROWCNT_EN adds a 16-bit count of rows handed downstream.
module systolic_drain import systolic_pkg::*; #(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH),
    localparam int ROW_W     = ARRAY_SIZE * ACC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ROW_W-1:0] output_row,
    systolic_drain_if.master out_bus,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             error
`ifdef SYSTOLIC_DRAIN_ROWCNT_EN
    ,
    output logic [15:0]      row_count
`endif
);
    localparam int CNT_W = $clog2(2 * ARRAY_SIZE);
    localparam int LAST  = 2 * ARRAY_SIZE - 2;

    logic [1:0]                             state;
    logic [CNT_W-1:0]                       cnt;
    logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]   lanes, aligned;
    logic                                   push, drop;

    assign lanes = output_row;

    // cnt reads 0 in the start cycle, so CAPTURE runs with cnt = 1 .. LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (start && state != ST_IDLE) error <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CAPTURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (cnt == CNT_W'(LAST)) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CAPTURE);
    assign done = (state == ST_DONE);
    assign push = busy && (cnt >= CNT_W'(ARRAY_SIZE - 1));

    // Lane j lags the last lane by ARRAY_SIZE-1-j cycles; delaying it that much lines the row up.
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
        localparam int D = ARRAY_SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j] = lanes[j];
        end else begin : g_dly
            logic [D-1:0][ACC_WIDTH-1:0] sr;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else begin
                    sr[0] <= lanes[j];
                    for (int s = 1; s < D; s++) sr[s] <= sr[s-1];
                end
            end
            assign aligned[j] = sr[D-1];
        end
    end

    systolic_drain_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (aligned),
        .pop       (out_bus.out_ready),
        .out_valid (out_bus.out_valid),
        .out_data  (out_bus.out_data),
        .drop      (drop)
    );

`ifdef SYSTOLIC_DRAIN_ROWCNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            row_count <= '0;
        else if (out_bus.out_valid && out_bus.out_ready)
            row_count <= row_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: scenario table, hand sequences and random tiles against a row-queue model.
module tb_systolic_drain;
    import systolic_pkg::*;

    localparam int N     = 8;
    localparam int DW    = 4;
    localparam int AW    = DW * DW;
    localparam int RW    = N * AW;
    localparam int DEPTH = 4;

    typedef logic [N-1:0][AW-1:0] row_t;

    localparam logic [RW-1:0] ROW0 = 128'h0070_0060_0050_0040_0030_0020_0010_0000;
    localparam logic [RW-1:0] ROW3 = 128'h0073_0063_0053_0043_0033_0023_0013_0003;
    localparam logic [RW-1:0] ROW7 = 128'h0077_0067_0057_0047_0037_0027_0017_0007;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [RW-1:0] output_row;
    logic          busy, done, overflow, error;
`ifdef SYSTOLIC_DRAIN_ROWCNT_EN
    logic [15:0]   row_count;
`endif

    systolic_drain_if #(.WIDTH(RW)) bus ();

    systolic_drain #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .output_row (output_row),
        .out_bus    (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .error      (error)
`ifdef SYSTOLIC_DRAIN_ROWCNT_EN
        ,
        .row_count  (row_count)
`endif
    );

    always #5 clk = ~clk;

    // Model: a tile accepted at cycle t0 has row r ready at offset r+N-1; the FIFO is a bounded queue.
    row_t        tile_m [N];
    row_t        q [$];
    row_t        popped [$];
    int          k, t0;
    bit          has_tile, m_ovf, m_err;
    int unsigned m_rcnt;
    int          errors, checks;

    typedef struct {
        string name;
        int    rdy_from;
        int    exp_rows;
        bit    exp_ovf;
        row_t  exp_first;
        row_t  exp_last;
    } vec_t;
    vec_t vecs [3];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_pattern();
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                tile_m[r][j] = AW'(16 * j + r);
    endtask

    task automatic cycle(input bit rst, input bit st, input bit rdy);
        int   off, r;
        bit   pop, push_v;
        row_t drv, exp_row;
        off = has_tile ? k - t0 : -1000;
        if (!rst && st) begin
            if (off >= 1 && off <= 2*N-1) m_err = 1'b1;
            else begin
                has_tile = 1'b1;
                t0       = k;
                off      = 0;
            end
        end
        for (int j = 0; j < N; j++) begin
            r = off - j;
            drv[j] = (has_tile && r >= 0 && r < N) ? tile_m[r][j] : AW'($urandom);
        end
        reset         = rst;
        start         = st;
        bus.out_ready = rdy;
        output_row    = drv;
        if (!rst && bus.out_valid && rdy) popped.push_back(bus.out_data);
        pop    = (q.size() != 0) && rdy;
        push_v = has_tile && off >= N-1 && off <= 2*N-2;
        if (rst) begin
            q.delete();
            m_ovf    = 1'b0;
            m_err    = 1'b0;
            has_tile = 1'b0;
            m_rcnt   = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_rcnt = (m_rcnt + 1) % 65536;
            end
            if (push_v) begin
                if (q.size() < DEPTH) q.push_back(tile_m[off-(N-1)]);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        k++;
        @(negedge clk);
        off = has_tile ? k - t0 : -1000;
        exp_row = '0;
        if (q.size() != 0) exp_row = q[0];
        chk("busy",      RW'(busy),          RW'(off >= 1 && off <= 2*N-2));
        chk("done",      RW'(done),          RW'(off == 2*N-1));
        chk("out_valid", RW'(bus.out_valid), RW'(q.size() != 0));
        chk("out_data",  bus.out_data,       exp_row);
        chk("overflow",  RW'(overflow),      RW'(m_ovf));
        chk("error",     RW'(error),         RW'(m_err));
`ifdef SYSTOLIC_DRAIN_ROWCNT_EN
        chk("row_count", RW'(row_count),     RW'(m_rcnt));
`endif
    endtask

    task automatic run_tile(input int rdy_from);
        cycle(1'b0, 1'b1, 0 >= rdy_from);
        for (int c = 1; c < 2*N; c++) cycle(1'b0, 1'b0, c >= rdy_from);
        for (int c = 0; c < DEPTH + 4; c++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_rows(input string name, input int n, input row_t first, input row_t last);
        row_t a_first, a_last;
        a_first = '0;
        a_last  = '0;
        if (popped.size() != 0) begin
            a_first = popped[0];
            a_last  = popped[popped.size()-1];
        end
        chk({name, ":rows"},  RW'(popped.size()), RW'(n));
        chk({name, ":first"}, a_first, first);
        chk({name, ":last"},  a_last,  last);
    endtask

    initial begin
        int gap, thr;
        errors   = 0;
        checks   = 0;
        k        = 0;
        t0       = 0;
        has_tile = 1'b0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_rcnt   = 0;

        vecs[0] = '{"basic",        0,   8, 1'b0, ROW0, ROW7};
        vecs[1] = '{"backpressure", 100, 4, 1'b1, ROW0, ROW3};
        vecs[2] = '{"full_pop",     11,  8, 1'b0, ROW0, ROW7};

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        for (int v = 0; v < 3; v++) begin
            cycle(1'b1, 1'b0, 1'b0);
            popped.delete();
            set_pattern();
            run_tile(vecs[v].rdy_from);
            chk({vecs[v].name, ":overflow"}, RW'(overflow), RW'(vecs[v].exp_ovf));
            chk_rows(vecs[v].name, vecs[v].exp_rows, vecs[v].exp_first, vecs[v].exp_last);
        end

        // Second start mid-tile is flagged but leaves the tile intact.
        cycle(1'b1, 1'b0, 1'b0);
        popped.delete();
        set_pattern();
        cycle(1'b0, 1'b1, 1'b1);
        for (int c = 1; c < 2*N; c++) cycle(1'b0, c == 3, 1'b1);
        for (int c = 0; c < DEPTH + 4; c++) cycle(1'b0, 1'b0, 1'b1);
        chk("protocol:error", RW'(error), RW'(1));
        chk_rows("protocol", 8, ROW0, ROW7);

        // Reset at cnt=5 aborts the tile; a fresh tile afterwards is clean.
        cycle(1'b1, 1'b0, 1'b0);
        popped.delete();
        cycle(1'b0, 1'b1, 1'b1);
        for (int c = 1; c < 5; c++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("rst_mid:busy",      RW'(busy),          RW'(0));
        chk("rst_mid:out_valid", RW'(bus.out_valid), RW'(0));
        for (int c = 0; c < 20; c++) cycle(1'b0, 1'b0, 1'b1);
        chk("rst_mid:no_rows", RW'(popped.size()), RW'(0));
        run_tile(0);
        chk_rows("rst_fresh", 8, ROW0, ROW7);

`ifdef SYSTOLIC_DRAIN_ROWCNT_EN
        cycle(1'b1, 1'b0, 1'b0);
        run_tile(0);
        run_tile(0);
        chk("row_count:two_tiles", RW'(row_count), RW'(16));
`endif

        // Random tiles, gaps, ready patterns and stray starts.
        cycle(1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 10; t++) begin
            for (int r = 0; r < N; r++)
                for (int j = 0; j < N; j++)
                    tile_m[r][j] = AW'($urandom);
            thr = $urandom_range(0, 3);
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, $urandom_range(0, 1) == 1);
            cycle(1'b0, 1'b1, $urandom_range(0, 3) >= thr);
            for (int c = 1; c < 2*N; c++)
                cycle(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) >= thr);
        end
        for (int c = 0; c < DEPTH + 4; c++) cycle(1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, number of PE columns (lanes) and result rows per tile.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, operand width; ACC_WIDTH = DATA_WIDTH*DATA_WIDTH is the per-lane result width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of deskewed rows buffered; power of two, >= 2.
REQ-004 Clocking: one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle pulse; lane 0 of row 0 is valid on output_row this cycle.
REQ-008 output_row  input  ARRAY_SIZE*ACC_WIDTH  skewed array results; lane j = output_row[j*ACC_WIDTH +: ACC_WIDTH].
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_valid  output  1  out_data holds a deskewed row.
REQ-011 out_data  output  ARRAY_SIZE*ACC_WIDTH  deskewed row, same lane packing as output_row.
REQ-012 busy  output  1  capture in progress.
REQ-013 done  output  1  one-cycle pulse after the last row of a tile is pushed.
REQ-014 overflow  output  1  sticky; a row was dropped because the FIFO was full.
REQ-015 error  output  1  sticky; start arrived while not IDLE.

Function
REQ-016 FSM states IDLE, CAPTURE, DONE; IDLE->CAPTURE on start; CAPTURE->DONE when cnt = 2*ARRAY_SIZE-2; DONE->IDLE unconditionally.
REQ-017 Capture counter cnt SHALL be 0 in the start cycle and increment by one each cycle while in CAPTURE.
REQ-018 Lane j of row r SHALL be sampled in the cycle cnt = r + j, for r in 0..ARRAY_SIZE-1.
REQ-019 Lane j SHALL pass through a (ARRAY_SIZE-1-j)-stage deskew delay, so row r is fully aligned at cnt = r + ARRAY_SIZE - 1.
REQ-020 Aligned row r SHALL be pushed into the FIFO at the clock edge ending cycle cnt = r + ARRAY_SIZE - 1, giving ARRAY_SIZE pushes per tile in row order.
REQ-021 busy SHALL be 1 exactly in CAPTURE; done SHALL be 1 exactly in DONE.
REQ-022 The FIFO is first-word-fall-through: out_valid = not empty; out_data = head row; pop on out_valid && out_ready.
REQ-023 Simultaneous push and pop when full SHALL succeed, with no drop and no overflow.
REQ-024 A push when full without a pop SHALL drop the incoming row, leave FIFO contents unchanged and set overflow.
REQ-025 start in CAPTURE or DONE SHALL be ignored and set error; the capture in progress continues unaffected.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; out_data SHALL be stable while out_valid && !out_ready.
REQ-027 No arithmetic is performed on results; lanes pass bit-exact.

Reset
REQ-028 reset SHALL force state=IDLE, cnt=0, FIFO empty, out_valid=0, out_data=0, busy=0, done=0, overflow=0, error=0, and clear the deskew stages.
REQ-029 reset mid-capture SHALL abort the tile; no partial rows appear afterward.

Configuration
REQ-030 Macro SYSTOLIC_DRAIN_ROWCNT_EN defined: SHALL add output row_count[15:0], reset to 0, incremented on each pop, wrapping 65535->0.
REQ-031 Macro SYSTOLIC_DRAIN_ROWCNT_EN undefined: the row_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package systolic_pkg SHALL hold default ARRAY_SIZE, DATA_WIDTH, the ACC_WIDTH derivation and the FSM state encoding.
REQ-033 The FIFO SHALL be the sub-module systolic_drain_fifo (parameters WIDTH, DEPTH); deskew and FSM stay in systolic_drain.

Verification (stimulus: lane j at cnt c driven as 16*j + (c-j); expected row r lane j = 16*j + r)
REQ-034 Basic: start, out_ready=1 -> 8 rows; first out_valid one cycle after cnt=7; row 0 = {0x70,...,0x10,0x00}, row 7 = {0x77,...,0x07}; done pulses once.
REQ-035 Backpressure: out_ready=0 for the whole tile -> rows 0..3 retained, rows 4..7 dropped, overflow=1; release -> exactly rows 0..3 in order.
REQ-036 Full plus pop: FIFO full with out_ready=1 during the push cycle -> no drop, overflow stays 0.
REQ-037 Protocol: second start at cnt=3 -> error=1, first tile output unchanged.
REQ-038 Reset at cnt=5 -> all outputs 0 the next cycle, no rows emitted; a fresh start then yields a correct tile.
REQ-039 With SYSTOLIC_DRAIN_ROWCNT_EN: two tiles drained -> row_count=16.
